// File: rtl/div_module.sv
// Iterative restoring divider producing MIPS DIV/DIVU results: quotient on lo, remainder on hi.
// One quotient bit per clock, with a start/busy/done handshake for pipeline stalls.
module div_module #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    // Magnitudes are held as WIDTH-bit unsigned, so |-2^(WIDTH-1)| is exact; the
    // partial remainder always stays below the divisor, only the shifted value needs WIDTH+1 bits.
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    quo_d   = (sign && A[WIDTH-1]) ? -A : A;
                    dvs_d   = (sign && B[WIDTH-1]) ? -B : B;
                    rem_d   = '0;
                    negq_d  = sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                    negr_d  = sign & A[WIDTH-1];
                    cnt_d   = CW'(WIDTH);
                    state_d = (B == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
                rem_d = shifted[WIDTH-1:0];
                if (shifted >= {1'b0, dvs_q}) begin
                    rem_d    = shifted[WIDTH-1:0] - dvs_q;
                    quo_d[0] = 1'b1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (dvs_q == '0) begin
                    lo_d  = '1;
                    hi_d  = a_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d  = negq_q ? -quo_q : quo_q;
                    hi_d  = negr_q ? -rem_q : rem_q;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_module.sv
// Directed self-checking bench for div_module: unsigned/signed results, divide-by-zero,
// signed overflow, start-while-busy and asynchronous reset mid-operation.
module tb_div_module;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    div_module #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sign        (sign),
        .A           (A),
        .B           (B),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one divide and waits for done. If intrude > 0, a second start (5/3)
    // is driven for one cycle that many cycles into the run.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_dbz, input int exp_lat, input int intrude);
        int edges;
        int busy_cycles;
        @(negedge clk);
        A = a; B = b; sign = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        busy_cycles = 0;
        while (!done && edges < 100) begin
            if (busy) busy_cycles++;
            if (start) start = 1'b0;
            if (intrude > 0 && edges == intrude) begin
                A = 32'd5; B = 32'd3; sign = 1'b1; start = 1'b1;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(edges), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, " done_fall"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int extra_done;
        int extra_busy;
        rst_n = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        A     = '0;
        B     = '0;
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33, 0);
        run_op("s-7_2",    32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33, 0);
        run_op("s7_-2",    32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33, 0);
        run_op("uffff_5",  32'hFFFFFFFF,   32'd5,          1'b0, 32'h33333333,   32'd0,          1'b0, 33, 0);
        run_op("s-1_5",    32'hFFFFFFFF,   32'd5,          1'b1, 32'd0,          32'hFFFFFFFF,   1'b0, 33, 0);
        run_op("u10_0",    32'd10,         32'd0,          1'b0, 32'hFFFFFFFF,   32'd10,         1'b1, 1,  0);
        run_op("u10_10",   32'd10,         32'd10,         1'b0, 32'd1,          32'd0,          1'b0, 33, 0);
        run_op("s-3_0",    32'hFFFFFFFD,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFD,   1'b1, 1,  0);
        run_op("s_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33, 10);

        // The ignored 5/3 request must not cause a restart or a second done.
        extra_done = 0;
        extra_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check("ovf extra_done", 32'(extra_done), 32'd0);
        check("ovf extra_busy", 32'(extra_busy), 32'd0);
        check("ovf lo_hold", lo, 32'h80000000);

        // Asynchronous reset 15 cycles into a 50/5 divide.
        @(negedge clk);
        A = 32'd50; B = 32'd5; sign = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        check("pre_rst busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("rst no_done", 32'(extra_done), 32'd0);

        run_op("u50_5",    32'd50,         32'd5,          1'b0, 32'd10,         32'd0,          1'b0, 33, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
